// File: rtl/seq1011_tx_pkg.sv
// State encoding and the shared default pattern for the 1011 pattern transmitter.
// The detector imports the same package so both ends agree on the default pattern.
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1011;

endpackage

// File: rtl/seq1011_tx_if.sv
// Request/stream bundle between a pattern requester (master) and seq1011_tx (slave).
interface seq1011_tx_if #(
  parameter int PAT_W = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic             use_default;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, use_default, pattern, reps,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, use_default, pattern, reps,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq1011_tx_piso.sv
// Parallel-load, MSB-first shift register; load takes priority over shift.
module seq_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  output logic [PAT_W-1:0] q_o
);
  logic [PAT_W-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)      sr_q <= '0;
    else if (load_i)  sr_q <= data_i;
    else if (shift_i) sr_q <= {sr_q[PAT_W-2:0], 1'b0};
  end

  assign q_o = sr_q;
endmodule

// File: rtl/seq1011_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, reps times.
// Define SEQ_TX_GAP_EN to insert GAP_LEN idle-zero bits between repetitions.
//
// state    | meaning
// IDLE     | waiting for start; outputs quiet
// SHIFT    | driving one pattern bit per cycle
// GAP      | driving zero gap bits between reps (SEQ_TX_GAP_EN only)
// DONE     | one-cycle completion pulse
module seq1011_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(SEQ_DEFAULT_PAT),
  parameter int               REP_W       = 4,
  parameter int               GAP_LEN     = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  seq1011_tx_if.slave  bus
);
  localparam int             BIT_W    = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sr_load, sr_shift;
  logic [PAT_W-1:0] sr_data, sr_q;
  logic [PAT_W-1:0] sel_pat;

`ifdef SEQ_TX_GAP_EN
  localparam int             GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  assign sel_pat = bus.use_default ? PAT_DEFAULT : bus.pattern;

  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (sr_data),
    .q_o     (sr_q)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    rep_d    = rep_q;
    bit_d    = bit_q;
    dout_d   = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_data  = pat_q;
`ifdef SEQ_TX_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pat_d   = sel_pat;
          rep_d   = (bus.reps == '0) ? REP_W'(1) : bus.reps;
          bit_d   = BIT_LAST;
          sr_load = 1'b1;
          sr_data = sel_pat;
          dout_d  = sel_pat[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (bit_q != '0) begin
          sr_shift = 1'b1;
          bit_d    = bit_q - BIT_W'(1);
          dout_d   = sr_q[PAT_W-2];
          valid_d  = 1'b1;
        end else if (rep_q > REP_W'(1)) begin
          rep_d   = rep_q - REP_W'(1);
          valid_d = 1'b1;
`ifdef SEQ_TX_GAP_EN
          gap_d   = GAP_LAST;
          state_d = ST_GAP;
`else
          sr_load = 1'b1;
          bit_d   = BIT_LAST;
          dout_d  = pat_q[PAT_W-1];
`endif
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
`ifdef SEQ_TX_GAP_EN
      ST_GAP: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else begin
          sr_load = 1'b1;
          bit_d   = BIT_LAST;
          dout_d  = pat_q[PAT_W-1];
          state_d = ST_SHIFT;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_TX_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_seq1011_tx.sv
// Randomized scoreboard bench for seq1011_tx; honours SEQ_TX_GAP_EN like the DUT.
module tb_seq1011_tx;
  localparam int PAT_W   = 4;
  localparam int REP_W   = 4;
  localparam int GAP_LEN = 2;
`ifdef SEQ_TX_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam logic [3:0] DEF_PAT = 4'b1011;
  localparam int DONE_MARK = 2;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  seq1011_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W)) bus ();

  seq1011_tx #(.PAT_W(PAT_W), .PAT_DEFAULT(DEF_PAT), .REP_W(REP_W), .GAP_LEN(GAP_LEN)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int len_q[$];
  int busy_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected stream: each rep is the pattern read MSB-first, optional zero gap between reps.
  task automatic model_push(input logic ud, input logic [3:0] pat, input logic [3:0] rp);
    logic [3:0] p;
    int re, len;
    p   = ud ? DEF_PAT : pat;
    re  = (rp == 0) ? 1 : int'(rp);
    len = 1;
    for (int r = 0; r < re; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) begin
        exp_q.push_back(int'(p[i]));
        len++;
      end
      if (GAP_EN && r < re - 1)
        for (int g = 0; g < GAP_LEN; g++) begin
          exp_q.push_back(0);
          len++;
        end
    end
    exp_q.push_back(DONE_MARK);
    len_q.push_back(len);
  endtask

  // Monitor: pops one expected item per valid bit or done pulse.
  always @(negedge clk_i) begin
    if (reset_i) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("dout", int'(bus.dout), exp_q.pop_front());
        chk("busy_with_valid", int'(bus.busy), 1);
      end else if (bus.dout !== 1'b0) begin
        chk("dout_idle_zero", int'(bus.dout), 0);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_order", exp_q.pop_front(), DONE_MARK);
        chk("busy_at_done", int'(bus.busy), 1);
        chk("valid_at_done", int'(bus.dout_valid), 0);
        if (len_q.size() != 0) chk("busy_len", busy_cnt, len_q.pop_front());
        busy_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run(input logic ud, input logic [3:0] pat, input logic [3:0] rp, input bit noisy);
    bit seen;
    model_push(ud, pat, rp);
    bus.start = 1'b1; bus.use_default = ud; bus.pattern = pat; bus.reps = rp;
    step();
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (noisy) begin
        bus.start = 1'b1;
        bus.use_default = 1'($urandom);
        bus.pattern = 4'($urandom);
        bus.reps = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) chk("done_timeout", 0, 1);
    step();
    chk("busy_after_done", int'(bus.busy), 0);
    bus.start = 1'b0;
    step();
    chk("no_restart", int'(bus.busy) + int'(bus.dout_valid), 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.use_default = 1'b0; bus.pattern = '0; bus.reps = '0;
    reset_i = 1'b1;
    step(); step();
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_valid", int'(bus.dout_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset_i = 1'b0;
    step();

    run(1'b1, 4'b0000, 4'd1, 1'b0);
    run(1'b0, 4'b1100, 4'd3, 1'b0);
    run(1'b1, 4'b0110, 4'd3, 1'b0);
    run(1'b1, 4'b0000, 4'd0, 1'b0);
    run(1'b0, 4'b0101, 4'd0, 1'b0);
    run(1'b1, 4'b0000, 4'd2, 1'b1);
    run(1'b0, 4'b1001, 4'd15, 1'b0);

    // Reset on the third busy cycle of a reps=2 run abandons it without a done pulse.
    model_push(1'b1, 4'b0000, 4'd2);
    bus.start = 1'b1; bus.use_default = 1'b1; bus.reps = 4'd2;
    step();
    bus.start = 1'b0;
    step(); step();
    reset_i = 1'b1;
    bus.start = 1'b1;
    step();
    exp_q.delete();
    len_q.delete();
    chk("midrst_dout", int'(bus.dout), 0);
    chk("midrst_valid", int'(bus.dout_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    reset_i = 1'b0;
    bus.start = 1'b0;
    step();
    chk("post_rst_idle", int'(bus.busy), 0);
    run(1'b1, 4'b0000, 4'd2, 1'b0);

    for (int k = 0; k < 20; k++)
      run(1'($urandom), 4'($urandom), 4'($urandom_range(0, 6)), 1'($urandom));

    step(); step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/seq1011_tx.md
Name: seq1011_tx

Overview:
- Serial pattern transmitter that drives the bit stream the team's 1011 sequence detectors consume.
- On a start request it captures an N-bit pattern (default 1011) and a repetition count, then shifts the pattern out MSB-first, one bit per clock.
- It flags each valid bit and pulses done on completion.
- Sits upstream of the detector as stimulus source and on-chip pattern generator.

Parameters:
- PAT_W, 4, pattern width in bits (≥2)
- PAT_DEFAULT, 4'b1011, pattern used when use_default=1
- REP_W, 4, width of repetition count
- GAP_LEN, 2, idle-zero bits between repetitions (used only with SEQ_TX_GAP_EN)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- use_default  input  1  1: send PAT_DEFAULT, 0: send pattern; sampled with start
- pattern  input  PAT_W  user pattern; sampled with start
- reps  input  REP_W  repetition count; 0 is treated as 1
- dout  output  1  serial data; 0 whenever dout_valid=0
- dout_valid  output  1  dout carries a transmitted bit this cycle
- busy  output  1  high from first bit through the done cycle
- done  output  1  one-cycle completion pulse

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- All outputs are registered. Reset values: dout=0, dout_valid=0, busy=0, done=0, state=IDLE, counters=0.
- States: IDLE, SHIFT, GAP (only with SEQ_TX_GAP_EN), DONE.
- IDLE:
  - start=1 at edge E0 captures the selected pattern into the shift register and max(reps,1) into the rep counter.
  - Bit counter is set to PAT_W-1; next state is SHIFT.
  - After E0: dout=pattern MSB, dout_valid=1, busy=1.
- SHIFT:
  - Each edge advances one bit, MSB→LSB.
  - When bit 0 of a repetition is driven and more reps remain, the next edge reloads the captured pattern and decrements the rep counter. Next state is SHIFT, or GAP when enabled.
  - When bit 0 of the last rep is driven, the next edge goes to DONE.
- DONE: lasts exactly one cycle with done=1, busy=1, dout_valid=0. Next edge goes to IDLE, busy=0.
- Latency:
  - First bit is visible in the cycle after the start edge.
  - Total busy cycles = reps_eff*PAT_W + 1 without gap; reps_eff*PAT_W + (reps_eff-1)*GAP_LEN + 1 with gap.
- Boundary conditions:
  - start while busy or in DONE: ignored, no queueing.
  - start at the same edge DONE→IDLE: ignored; start must be seen in IDLE.
  - pattern, reps and use_default changing mid-run: no effect, values were captured at start.
  - reps=0: behaves exactly as reps=1.
  - reps at its maximum (2^REP_W-1): full count sent, no wrap.
  - reset asserted mid-run: at the next edge all outputs return to reset values and the partial stream is abandoned, with no done pulse.
  - reset and start at the same edge: reset wins.
- Ordering is MSB-first.
- Counters:
  - Bit counter width is $clog2(PAT_W).
  - Rep counter width is REP_W; it decrements and never underflows.

Optional Feature:
- Macro: SEQ_TX_GAP_EN.
- Defined:
  - GAP state inserts GAP_LEN cycles between consecutive repetitions with dout=0, dout_valid=1, busy=1.
  - No gap after the last rep.
  - Gives the detector a resynchronisation window.
- Undefined:
  - Repetitions are back-to-back; GAP state and gap counter are not synthesised.
  - GAP_LEN is unused.

Decomposition:
- Package seq_pkg holds:
  - state encoding constants (IDLE, SHIFT, GAP, DONE, 2 bits);
  - the shared default pattern constant 4'b1011, which the detector should reference too.
- One sub-module, seq_piso: PAT_W-bit parallel-load, MSB-first shift register with load/shift enables and synchronous reset.
- FSM and counters live in seq1011_tx.

Test Plan:
- Single rep: reset 2 cycles; use_default=1, reps=1, start 1 cycle → dout_valid=1 for 4 cycles with dout 1,0,1,1; done=1 on cycle 5; busy high cycles 1–5; a detector fed dout/dout_valid pulses exactly once.
- Repeats: pattern=4'b1100, use_default=0, reps=3 → 12 valid bits 110011001100, done on cycle 13. The same with PAT_DEFAULT gives 101110111011 and three detector hits.
- reps=0 → identical to the reps=1 waveform.
- Ignored inputs: start pulses every cycle during a reps=2 run, and pattern changed mid-run → output unaffected, no second run begins until after DONE.
- Reset: reset asserted on cycle 3 of a reps=2 run → next cycle dout=0, dout_valid=0, busy=0, done=0; a new start afterwards runs cleanly.
- SEQ_TX_GAP_EN, GAP_LEN=2, reps=2, default pattern → valid stream 1011 00 1011, done on cycle 11. Without the macro the same stimulus gives 10111011, done on cycle 9.
